uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 148 ++++++++++++++
 tb/tb_uart_rx_fifo.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive FIFO between a byte-wide UART receiver and a consumer, first-word fall-through.
// Define UART_RX_FIFO_DROP_EN to drop (and flag in ovf) bytes arriving while full; otherwise the UART is back-pressured.
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    uart_rx_data,
    input  logic          uart_rx_valid,
    output logic          uart_rx_re,
    input  logic          rd_en,
    output logic [7:0]    rd_data,
    output logic          rd_valid,
    output logic [AW:0]   count,
    output logic          full,
    output logic          ovf,
    input  logic          ovf_clr
);

    localparam int CW = AW + 1;
    localparam logic [0:0]    S_IDLE  = 1'b0;
    localparam logic [0:0]    S_WAIT  = 1'b1;
    localparam logic [AW:0]   DEPTH_C = CW'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = CW'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [7:0]    mem_r [DEPTH];
    logic [0:0]    state_r;
    logic [0:0]    state_s;
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic [AW:0]   count_s;
    logic          full_r;
    logic          rd_valid_r;
    logic          ovf_r;
    logic          ovf_s;
    logic          pop_s;
    logic          push_s;
    logic          drop_s;
    logic          ack_s;

    // Capture decision, next state, occupancy and overflow next values
    always_comb begin
        pop_s   = rd_en & rd_valid_r;
        push_s  = 1'b0;
        drop_s  = 1'b0;
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (uart_rx_valid) begin
                    // A same-cycle pop frees the slot, so a full FIFO can still take the byte.
                    if (!full_r || pop_s) begin
                        push_s = 1'b1;
                    end else begin
`ifdef UART_RX_FIFO_DROP_EN
                        drop_s = 1'b1;
`else
                        drop_s = 1'b0;
`endif
                    end
                end else begin
                    push_s = 1'b0;
                end
                if (push_s || drop_s) begin
                    state_s = S_WAIT;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_WAIT: begin
                if (!uart_rx_valid) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_WAIT;
                end
            end
            default: state_s = S_IDLE;
        endcase

        ack_s = push_s | drop_s;

        case ({push_s, pop_s})
            2'b10:   count_s = count_r + CNT_ONE;
            2'b01:   count_s = count_r - CNT_ONE;
            default: count_s = count_r;
        endcase

`ifdef UART_RX_FIFO_DROP_EN
        if (drop_s) begin
            ovf_s = 1'b1;
        end else if (ovf_clr) begin
            ovf_s = 1'b0;
        end else begin
            ovf_s = ovf_r;
        end
`else
        // Nothing can set ovf without dropping; the clear path keeps it pinned at 0.
        ovf_s = ovf_r & ~ovf_clr;
`endif
    end

    // Control state, pointers and registered status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= S_IDLE;
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
            full_r     <= 1'b0;
            rd_valid_r <= 1'b0;
            ovf_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            count_r    <= count_s;
            full_r     <= (count_s == DEPTH_C);
            rd_valid_r <= (count_s != {CW{1'b0}});
            ovf_r      <= ovf_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    // Storage array, intentionally not reset
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= uart_rx_data;
        end
    end

    // The acknowledge is a Mealy pulse in the accepting IDLE cycle; reset masks it.
    assign uart_rx_re = ack_s & ~rst;
    assign rd_data    = rd_valid_r ? mem_r[rd_ptr_r] : 8'h00;
    assign rd_valid   = rd_valid_r;
    assign count      = count_r;
    assign full       = full_r;
    assign ovf        = ovf_r;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus random traffic against a queue model.
// Build with UART_RX_FIFO_DROP_EN defined to exercise the drop-on-full configuration.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
`ifdef UART_RX_FIFO_DROP_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    logic          clk           = 1'b0;
    logic          rst           = 1'b1;
    logic [7:0]    uart_rx_data  = 8'h00;
    logic          uart_rx_valid = 1'b0;
    logic          uart_rx_re;
    logic          rd_en         = 1'b0;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic [AW:0]   count;
    logic          full;
    logic          ovf;
    logic          ovf_clr       = 1'b0;

    always #5 clk = ~clk;

    uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid), .uart_rx_re(uart_rx_re),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
        .count(count), .full(full), .ovf(ovf), .ovf_clr(ovf_clr)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: stored bytes in arrival order, and whether the current UART byte was already taken.
    logic [7:0] q[$];
    bit         m_busy = 1'b0;
    bit         m_ovf  = 1'b0;
    bit         m_ack  = 1'b0;

    logic       rst_req   = 1'b1;
    logic       src_valid = 1'b0;
    logic [7:0] src_data  = 8'h00;
    logic       rd_req    = 1'b0;
    logic       clr_req   = 1'b0;
    int         re_cnt    = 0;
    int         max_count = 0;
    logic [7:0] exp_vals[DEPTH];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: apply inputs after the falling edge, check against the model, then advance the model.
    task automatic tick();
        int sz;
        bit pop, acc, drp;
        @(negedge clk);
        rst = rst_req; uart_rx_valid = src_valid; uart_rx_data = src_data;
        rd_en = rd_req; ovf_clr = clr_req;
        #1;
        if (rst_req) begin
            q.delete(); m_busy = 1'b0; m_ovf = 1'b0;
        end
        sz  = q.size();
        pop = !rst_req && rd_req && (sz > 0);
        acc = 1'b0; drp = 1'b0;
        if (!rst_req && !m_busy && src_valid) begin
            if (sz < DEPTH || pop) acc = 1'b1;
            else if (DROP) drp = 1'b1;
        end
        m_ack = acc || drp;
        check_eq("re", uart_rx_re, m_ack);
        check_eq("rd_valid", rd_valid, sz != 0);
        check_eq("rd_data", rd_data, (sz != 0) ? q[0] : 8'h00);
        check_eq("count", count, sz);
        check_eq("full", full, sz == DEPTH);
        check_eq("ovf", ovf, m_ovf);
        if (uart_rx_re) re_cnt++;
        if (int'(count) > max_count) max_count = int'(count);
        if (!rst_req) begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(src_data);
            if (acc || drp) m_busy = 1'b1;
            else if (!src_valid) m_busy = 1'b0;
            if (drp) m_ovf = 1'b1;
            else if (clr_req) m_ovf = 1'b0;
        end
    endtask

    // Present a byte until acknowledged, keep it up hold more cycles, then drop valid for one cycle.
    task automatic send(input logic [7:0] d, input int hold);
        int n = 0;
        bit got = 1'b0;
        src_valid = 1'b1; src_data = d;
        while (!got && n < 200) begin
            tick();
            got = m_ack;
            n++;
        end
        check_eq("send_ack", got, 1'b1);
        repeat (hold) tick();
        src_valid = 1'b0;
        tick();
    endtask

    task automatic fill(input int n, input bit rnd);
        rd_req = 1'b0;
        for (int i = 0; i < n; i++) begin
            exp_vals[i] = rnd ? 8'($urandom) : 8'(i);
            send(exp_vals[i], int'($urandom_range(0, 1)));
        end
    endtask

    task automatic drain(input int n);
        rd_req = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            check_eq("drain_data", rd_data, exp_vals[i]);
        end
        rd_req = 1'b0;
        tick();
        check_eq("drain_empty", rd_valid, 1'b0);
    endtask

    initial begin
        int  hold;
        bit  acked;

        repeat (3) tick();
        check_eq("reset_count", count, 0);
        check_eq("reset_rd_data", rd_data, 8'h00);
        rst_req = 1'b0;
        tick();

        // Single byte
        re_cnt = 0;
        send(8'hA5, 0);
        repeat (2) tick();
        check_eq("single_re_pulses", re_cnt, 1);
        check_eq("single_data", rd_data, 8'hA5);
        check_eq("single_count", count, 1);
        rd_req = 1'b1; tick(); rd_req = 1'b0; tick();
        check_eq("single_rd_valid", rd_valid, 1'b0);
        check_eq("single_count0", count, 0);

        // Fill and drain in order
        fill(DEPTH, 1'b0);
        check_eq("fill_full", full, 1'b1);
        check_eq("fill_count", count, DEPTH);
        drain(DEPTH);

        // Byte arriving while full
        fill(DEPTH, 1'b1);
`ifdef UART_RX_FIFO_DROP_EN
        re_cnt = 0;
        send(8'h77, 0);
        check_eq("ovf_re", re_cnt, 1);
        check_eq("ovf_set", ovf, 1'b1);
        check_eq("ovf_count", count, DEPTH);
        clr_req = 1'b1; tick(); clr_req = 1'b0; tick();
        check_eq("ovf_cleared", ovf, 1'b0);
        drain(DEPTH);
`else
        src_valid = 1'b1; src_data = 8'h77;
        re_cnt = 0;
        repeat (4) tick();
        check_eq("bp_no_re", re_cnt, 0);
        rd_req = 1'b1; tick(); rd_req = 1'b0;
        check_eq("bp_capture", uart_rx_re, 1'b1);
        src_valid = 1'b0; tick();
        check_eq("bp_count", count, DEPTH);
        for (int i = 0; i < DEPTH - 1; i++) exp_vals[i] = exp_vals[i + 1];
        exp_vals[DEPTH - 1] = 8'h77;
        drain(DEPTH);
        check_eq("bp_ovf", ovf, 1'b0);
`endif

        // Streaming with a pop every cycle, across pointer wrap
        rd_req = 1'b1; max_count = 0;
        for (int i = 0; i < 20; i++) send(8'($urandom), 0);
        check_eq("stream_max_count", max_count <= 1, 1'b1);
        rd_req = 1'b0; tick();
        check_eq("stream_empty", rd_valid, 1'b0);

        // Reset while in WAIT with five bytes stored
        fill(4, 1'b1);
        src_valid = 1'b1; src_data = 8'h5A;
        tick();
        tick();
        check_eq("mid_count5", count, 5);
        rst_req = 1'b1; src_data = 8'h3C; re_cnt = 0;
        tick();
        check_eq("mid_rst_count", count, 0);
        check_eq("mid_rst_rd_valid", rd_valid, 1'b0);
        tick();
        check_eq("mid_rst_re", re_cnt, 0);
        rst_req = 1'b0;
        tick();
        check_eq("post_rst_re", uart_rx_re, 1'b1);
        src_valid = 1'b0; tick();
        check_eq("post_rst_data", rd_data, 8'h3C);
        check_eq("post_rst_count", count, 1);
        rd_req = 1'b1; tick(); rd_req = 1'b0; tick();

        // Random traffic: fill-heavy first half, drain-heavy second half
        acked = 1'b0; hold = 0;
        for (int i = 0; i < 3000; i++) begin
            rd_req  = (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            clr_req = ($urandom_range(0, 15) == 0);
            if (!src_valid) begin
                if ($urandom_range(0, 2) == 0) begin
                    src_valid = 1'b1; src_data = 8'($urandom); acked = 1'b0;
                end
            end else if (acked) begin
                if (hold == 0) src_valid = 1'b0;
                else hold--;
            end
            tick();
            if (m_ack) begin
                acked = 1'b1; hold = int'($urandom_range(0, 2));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
